// File: rtl/fpga_pll_seq_pkg.sv
// Shared types and constants for the PLL power-up sequencer.
package fpga_pll_seq_pkg;

    localparam int unsigned CntW   = 16;
    localparam int unsigned RetryW = 4;

    typedef enum logic [2:0] {
        StPllRst   = 3'd0,
        StWaitLock = 3'd1,
        StStable   = 3'd2,
        StRun      = 3'd3,
        StFail     = 3'd4
    } seq_state_e;

endpackage

// File: rtl/fpga_sync_2ff.sv
// Two-flop synchronizer with asynchronous active-high reset.
module fpga_sync_2ff #(
    parameter int unsigned Width = 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [Width-1:0] d_i,
    output logic [Width-1:0] q_o
);

    logic [Width-1:0] meta_q;
    logic [Width-1:0] sync_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/fpga_pll_seq.sv
// PLL reset/lock sequencer for the sys and audio PLLs, clocked by the free-running oscillator.
// Define FPGA_PLL_SEQ_AUDIO_EN to sequence the audio PLL; otherwise only the sys PLL is used.
module fpga_pll_seq
    import fpga_pll_seq_pkg::*;
#(
    parameter int unsigned RST_HOLD   = 16,
    parameter int unsigned LOCK_WAIT  = 50000,
    parameter int unsigned STABLE_CNT = 1024,
    parameter int unsigned MAX_RETRY  = 3
) (
    input  logic              osc_clk_i,
    input  logic              reset_i,
    input  logic [1:0]        pll_locked_i,
    input  logic              sw_reset_req_i,
    output logic [1:0]        pll_areset_o,
    output logic              sys_reset_n_o,
    output logic              audio_reset_n_o,
    output logic              lock_fail_o,
    output logic [RetryW-1:0] retry_cnt_o,
    output logic [2:0]        seq_state_o
);

    if (RST_HOLD == 0 || RST_HOLD > 65535 || LOCK_WAIT == 0 || LOCK_WAIT > 65535 ||
        STABLE_CNT == 0 || STABLE_CNT > 65535) begin : g_param_chk
        $error("fpga_pll_seq: RST_HOLD, LOCK_WAIT and STABLE_CNT must be in 1..65535");
    end

    localparam logic [CntW-1:0]   RstLast    = CntW'(RST_HOLD - 1);
    localparam logic [CntW-1:0]   LockLast   = CntW'(LOCK_WAIT - 1);
    localparam logic [CntW-1:0]   StableLast = CntW'(STABLE_CNT - 1);
    localparam logic [RetryW-1:0] RetrySat   = {RetryW{1'b1}};

    logic both_locked;

`ifdef FPGA_PLL_SEQ_AUDIO_EN
    logic [1:0] lock_sync;

    fpga_sync_2ff #(
        .Width(2)
    ) u_lock_sync (
        .clk_i(osc_clk_i),
        .rst_i(reset_i),
        .d_i  (pll_locked_i),
        .q_o  (lock_sync)
    );

    assign both_locked = &lock_sync;
`else
    logic [0:0] lock_sync;
    logic       unused_audio_lock;

    fpga_sync_2ff #(
        .Width(1)
    ) u_lock_sync (
        .clk_i(osc_clk_i),
        .rst_i(reset_i),
        .d_i  (pll_locked_i[0]),
        .q_o  (lock_sync)
    );

    // Audio lock is treated as permanently high.
    assign unused_audio_lock = pll_locked_i[1];
    assign both_locked       = lock_sync[0];
`endif

    seq_state_e        state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [RetryW-1:0] retry_q, retry_d;
    logic [1:0]        areset_q, areset_d;
    logic              sys_rst_n_q, sys_rst_n_d;
    logic              aud_rst_n_q, aud_rst_n_d;
    logic              lock_fail_q, lock_fail_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 1'b1;
        retry_d = retry_q;
        unique case (state_q)
            StPllRst: begin
                if (sw_reset_req_i) begin
                    cnt_d = '0;
                end else if (cnt_q == RstLast) begin
                    state_d = StWaitLock;
                    cnt_d   = '0;
                end
            end
            StWaitLock: begin
                if (sw_reset_req_i) begin
                    state_d = StPllRst;
                    cnt_d   = '0;
                end else if (both_locked) begin
                    state_d = StStable;
                    cnt_d   = '0;
                end else if (cnt_q == LockLast) begin
                    cnt_d   = '0;
                    retry_d = (retry_q == RetrySat) ? retry_q : retry_q + 1'b1;
                    state_d = (32'(retry_d) >= MAX_RETRY) ? StFail : StPllRst;
                end
            end
            StStable: begin
                if (sw_reset_req_i) begin
                    state_d = StPllRst;
                    cnt_d   = '0;
                end else if (!both_locked) begin
                    state_d = StWaitLock;
                    cnt_d   = '0;
                end else if (cnt_q == StableLast) begin
                    state_d = StRun;
                    cnt_d   = '0;
                    retry_d = '0;
                end
            end
            StRun: begin
                cnt_d = '0;
                // A coincident request and lock loss collapse into one restart.
                if (sw_reset_req_i || !both_locked) begin
                    state_d = StPllRst;
                end
            end
            StFail: begin
                cnt_d = '0;
                if (sw_reset_req_i) begin
                    state_d = StPllRst;
                    retry_d = '0;
                end
            end
            default: begin
                state_d = StPllRst;
                cnt_d   = '0;
            end
        endcase
    end

    // Outputs are decoded from the next state so they change on the same edge as the state.
    always_comb begin
        areset_d    = (state_d == StPllRst || state_d == StFail) ? 2'b11 : 2'b00;
        sys_rst_n_d = (state_d == StRun);
        lock_fail_d = (state_d == StFail);
`ifdef FPGA_PLL_SEQ_AUDIO_EN
        aud_rst_n_d = (state_d == StRun);
`else
        aud_rst_n_d = 1'b0;
`endif
    end

    always_ff @(posedge osc_clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q     <= StPllRst;
            cnt_q       <= '0;
            retry_q     <= '0;
            areset_q    <= 2'b11;
            sys_rst_n_q <= 1'b0;
            aud_rst_n_q <= 1'b0;
            lock_fail_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            retry_q     <= retry_d;
            areset_q    <= areset_d;
            sys_rst_n_q <= sys_rst_n_d;
            aud_rst_n_q <= aud_rst_n_d;
            lock_fail_q <= lock_fail_d;
        end
    end

    assign pll_areset_o    = areset_q;
    assign sys_reset_n_o   = sys_rst_n_q;
    assign audio_reset_n_o = aud_rst_n_q;
    assign lock_fail_o     = lock_fail_q;
    assign retry_cnt_o     = retry_q;
    assign seq_state_o     = state_q;

endmodule

// File: tb/tb_fpga_pll_seq.sv
// Self-checking bench for fpga_pll_seq: hand sequences plus a timeout/FAIL vector table.
module tb_fpga_pll_seq;
    import fpga_pll_seq_pkg::*;

`ifdef FPGA_PLL_SEQ_AUDIO_EN
    localparam bit AudEn = 1'b1;
`else
    localparam bit AudEn = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] locked;
    logic       sw;
    logic [1:0] pll_areset;
    logic       sys_reset_n;
    logic       audio_reset_n;
    logic       lock_fail;
    logic [3:0] retry_cnt;
    logic [2:0] seq_state;

    fpga_pll_seq #(
        .RST_HOLD  (16),
        .LOCK_WAIT (100),
        .STABLE_CNT(1024),
        .MAX_RETRY (3)
    ) dut (
        .osc_clk_i      (clk),
        .reset_i        (rst),
        .pll_locked_i   (locked),
        .sw_reset_req_i (sw),
        .pll_areset_o   (pll_areset),
        .sys_reset_n_o  (sys_reset_n),
        .audio_reset_n_o(audio_reset_n),
        .lock_fail_o    (lock_fail),
        .retry_cnt_o    (retry_cnt),
        .seq_state_o    (seq_state)
    );

    always #5 clk = ~clk;

    typedef struct {
        string      name;
        logic [2:0] st;
        logic [1:0] ar;
        logic       sn;
        logic       an;
        logic       lf;
        logic [3:0] rc;
    } exp_t;

    typedef struct {
        logic [1:0] lk;
        logic       sw;
        int         n;
        logic [2:0] st;
        logic [1:0] ar;
        logic       sn;
        logic       lf;
        logic [3:0] rc;
    } vec_t;

    exp_t exp_q[$];
    vec_t vecs[$];
    int   compared   = 0;
    int   mismatched = 0;
    int   ar_bad     = 0;

    // With the audio PLL disabled, areset[1] must track areset[0] and audio reset stays low.
    always @(negedge clk) begin
        if (!rst && !AudEn && (pll_areset[1] !== pll_areset[0] || audio_reset_n !== 1'b0))
            ar_bad++;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, want $finish");
        $fatal(1);
    end

    task automatic step(input int n);
        if (n > 0) begin
            repeat (n) @(posedge clk);
            #1;
        end
    endtask

    task automatic push_exp(input string nm, input logic [2:0] st, input logic [1:0] ar,
                            input logic sn, input logic lf, input logic [3:0] rc);
        exp_t e;
        e.name = nm;
        e.st   = st;
        e.ar   = ar;
        e.sn   = sn;
        e.an   = AudEn ? sn : 1'b0;
        e.lf   = lf;
        e.rc   = rc;
        exp_q.push_back(e);
    endtask

    task automatic pop_check();
        exp_t e;
        compared++;
        if (exp_q.size() == 0) begin
            mismatched++;
            $display("FAIL scoreboard: got empty queue, want an expected record");
        end else begin
            e = exp_q.pop_front();
            if (seq_state !== e.st || pll_areset !== e.ar || sys_reset_n !== e.sn ||
                audio_reset_n !== e.an || lock_fail !== e.lf || retry_cnt !== e.rc) begin
                mismatched++;
                $display("FAIL %s: got st=%0d ar=%b sn=%b an=%b lf=%b rc=%0d, want st=%0d ar=%b sn=%b an=%b lf=%b rc=%0d",
                         e.name, seq_state, pll_areset, sys_reset_n, audio_reset_n, lock_fail,
                         retry_cnt, e.st, e.ar, e.sn, e.an, e.lf, e.rc);
            end
        end
    endtask

    task automatic expect_state(input string nm, input int n, input logic [2:0] st,
                                input logic [1:0] ar, input logic sn, input logic lf,
                                input logic [3:0] rc);
        push_exp(nm, st, ar, sn, lf, rc);
        step(n);
        pop_check();
    endtask

    logic [1:0] full;
    logic [1:0] glitch_bit;
    logic [2:0] prev_st;
    int         entries;

    initial begin
        full       = AudEn ? 2'b11 : 2'b01;
        glitch_bit = AudEn ? 2'b10 : 2'b01;
        rst        = 1'b1;
        locked     = full;
        sw         = 1'b0;

        // Power-up: locks already high, so WAIT_LOCK lasts a single cycle.
        repeat (5) @(posedge clk);
        #1;
        expect_state("in_reset", 0, StPllRst, 2'b11, 1'b0, 1'b0, 4'd0);
        rst = 1'b0;
        expect_state("rst_hold_end",   15,   StPllRst,   2'b11, 1'b0, 1'b0, 4'd0);
        expect_state("areset_release", 1,    StWaitLock, 2'b00, 1'b0, 1'b0, 4'd0);
        expect_state("stable_enter",   1,    StStable,   2'b00, 1'b0, 1'b0, 4'd0);
        expect_state("stable_last",    1023, StStable,   2'b00, 1'b0, 1'b0, 4'd0);
        expect_state("run_enter",      1,    StRun,      2'b00, 1'b1, 1'b0, 4'd0);

        // Loss of sys lock in RUN: two synchronizer cycles, then reset on the next edge.
        locked = full & 2'b10;
        expect_state("loss_sync",  2, StRun,    2'b00, 1'b1, 1'b0, 4'd0);
        expect_state("loss_reset", 1, StPllRst, 2'b11, 1'b0, 1'b0, 4'd0);
        locked = full;
        expect_state("loss_hold",     15, StPllRst,   2'b11, 1'b0, 1'b0, 4'd0);
        expect_state("loss_release",  1,  StWaitLock, 2'b00, 1'b0, 1'b0, 4'd0);
        expect_state("relock_stable", 1,  StStable,   2'b00, 1'b0, 1'b0, 4'd0);

        // Three-cycle lock glitch at STABLE count 500.
        expect_state("stable_500", 500, StStable, 2'b00, 1'b0, 1'b0, 4'd0);
        locked = full & ~glitch_bit;
        expect_state("glitch_seen", 3, StWaitLock, 2'b00, 1'b0, 1'b0, 4'd0);
        locked = full;
        expect_state("glitch_wait",        2,    StWaitLock, 2'b00, 1'b0, 1'b0, 4'd0);
        expect_state("glitch_relock",      1,    StStable,   2'b00, 1'b0, 1'b0, 4'd0);
        expect_state("glitch_stable_last", 1023, StStable,   2'b00, 1'b0, 1'b0, 4'd0);
        expect_state("glitch_run",         1,    StRun,      2'b00, 1'b1, 1'b0, 4'd0);

        // sw_reset_req lands on the same edge the synchronized lock loss reaches the FSM.
        locked = full & 2'b10;
        step(2);
        prev_st = seq_state;
        sw      = 1'b1;
        entries = 0;
        for (int i = 0; i < 20; i++) begin
            step(1);
            if (i == 0) begin
                sw     = 1'b0;
                locked = full;
            end
            if (seq_state == 3'(StPllRst) && prev_st != 3'(StPllRst)) entries++;
            prev_st = seq_state;
        end
        compared++;
        if (entries != 1) begin
            mismatched++;
            $display("FAIL sim_entries: got %0d PLL_RST entries, want 1", entries);
        end
        expect_state("sim_after", 0, StStable, 2'b00, 1'b0, 1'b0, 4'd0);

        // Timeout ladder to FAIL, then recovery by sw_reset_req.
        vecs.push_back('{2'b00, 1'b1, 1,  StPllRst,   2'b11, 1'b0, 1'b0, 4'd0});
        vecs.push_back('{2'b00, 1'b0, 15, StPllRst,   2'b11, 1'b0, 1'b0, 4'd0});
        vecs.push_back('{2'b00, 1'b0, 1,  StWaitLock, 2'b00, 1'b0, 1'b0, 4'd0});
        vecs.push_back('{2'b00, 1'b0, 99, StWaitLock, 2'b00, 1'b0, 1'b0, 4'd0});
        vecs.push_back('{2'b00, 1'b0, 1,  StPllRst,   2'b11, 1'b0, 1'b0, 4'd1});
        vecs.push_back('{2'b00, 1'b0, 15, StPllRst,   2'b11, 1'b0, 1'b0, 4'd1});
        vecs.push_back('{2'b00, 1'b0, 1,  StWaitLock, 2'b00, 1'b0, 1'b0, 4'd1});
        vecs.push_back('{2'b00, 1'b0, 99, StWaitLock, 2'b00, 1'b0, 1'b0, 4'd1});
        vecs.push_back('{2'b00, 1'b0, 1,  StPllRst,   2'b11, 1'b0, 1'b0, 4'd2});
        vecs.push_back('{2'b00, 1'b0, 15, StPllRst,   2'b11, 1'b0, 1'b0, 4'd2});
        vecs.push_back('{2'b00, 1'b0, 1,  StWaitLock, 2'b00, 1'b0, 1'b0, 4'd2});
        vecs.push_back('{2'b00, 1'b0, 99, StWaitLock, 2'b00, 1'b0, 1'b0, 4'd2});
        vecs.push_back('{2'b00, 1'b0, 1,  StFail,     2'b11, 1'b0, 1'b1, 4'd3});
        vecs.push_back('{2'b00, 1'b0, 50, StFail,     2'b11, 1'b0, 1'b1, 4'd3});
        vecs.push_back('{full,  1'b0, 10, StFail,     2'b11, 1'b0, 1'b1, 4'd3});
        vecs.push_back('{full,  1'b1, 1,  StPllRst,   2'b11, 1'b0, 1'b0, 4'd0});
        vecs.push_back('{full,  1'b0, 15, StPllRst,   2'b11, 1'b0, 1'b0, 4'd0});
        vecs.push_back('{full,  1'b0, 1,  StWaitLock, 2'b00, 1'b0, 1'b0, 4'd0});
        vecs.push_back('{full,  1'b0, 1,  StStable,   2'b00, 1'b0, 1'b0, 4'd0});
        vecs.push_back('{full,  1'b0, 1023, StStable, 2'b00, 1'b0, 1'b0, 4'd0});
        vecs.push_back('{full,  1'b0, 1,  StRun,      2'b00, 1'b1, 1'b0, 4'd0});

        for (int i = 0; i < vecs.size(); i++) begin
            locked = vecs[i].lk;
            sw     = vecs[i].sw;
            push_exp($sformatf("vec%0d", i), vecs[i].st, vecs[i].ar, vecs[i].sn, vecs[i].lf,
                     vecs[i].rc);
            step(1);
            sw = 1'b0;
            step(vecs[i].n - 1);
            pop_check();
        end

        // Asynchronous reset in RUN takes effect without a clock edge.
        #2;
        rst = 1'b1;
        #1;
        expect_state("async_reset", 0, StPllRst, 2'b11, 1'b0, 1'b0, 4'd0);
        step(2);
        rst = 1'b0;
        expect_state("rst_restart", 16, StWaitLock, 2'b00, 1'b0, 1'b0, 4'd0);

        compared++;
        if (ar_bad != 0) begin
            mismatched++;
            $display("FAIL audio_disabled_outputs: got %0d bad cycles, want 0", ar_bad);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
